// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/memory status in, freeze/flush out.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             two_src;
    logic [3:0]       ex_dest;
    logic [3:0]       mem_dest;
    logic             ex_wb_en;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             if_freeze;
    logic             ifreg_freeze;
    logic             ifreg_flush;
    logic             idreg_flush;
    logic             pipe_freeze;
    logic             fault;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output src1, src2, two_src, ex_dest, mem_dest,
        output ex_wb_en, mem_wb_en, branch_taken,
        output mem_req, mem_ready,
        input  if_freeze, ifreg_freeze, ifreg_flush,
        input  idreg_flush, pipe_freeze,
        input  fault, state, stall_cnt
    );

    modport slave (
        input  src1, src2, two_src, ex_dest, mem_dest,
        input  ex_wb_en, mem_wb_en, branch_taken,
        input  mem_req, mem_ready,
        output if_freeze, ifreg_freeze, ifreg_flush,
        output idreg_flush, pipe_freeze,
        output fault, state, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: boot hold, RAW interlock,
// branch flush, memory wait with timeout fault, stall counter.
module pipe_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BOOT_LAST =
        BW'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t           st_q, st_nxt;
    logic [BW-1:0]    boot_q, boot_nxt;
    logic [TW-1:0]    tmo_q, tmo_nxt;
    logic [CNT_W-1:0] stall_q;

    logic hazard, memstall, go;
    logic if_frz, ifr_frz, ifr_fl, idr_fl, p_frz;

    assign hazard =
        (bus.ex_wb_en & (bus.ex_dest == bus.src1)) |
        (bus.ex_wb_en & bus.two_src & (bus.ex_dest == bus.src2)) |
        (bus.mem_wb_en & (bus.mem_dest == bus.src1)) |
        (bus.mem_wb_en & bus.two_src & (bus.mem_dest == bus.src2));
    assign memstall = bus.mem_req & ~bus.mem_ready;

    always_comb begin
        st_nxt   = st_q;
        boot_nxt = boot_q;
        tmo_nxt  = tmo_q;
        if_frz   = 1'b0;
        ifr_frz  = 1'b0;
        ifr_fl   = 1'b0;
        idr_fl   = 1'b0;
        p_frz    = 1'b0;
        go       = 1'b0;
        unique case (st_q)
            BOOT: begin
                {if_frz, ifr_frz, p_frz} = 3'b111;
                if (BOOT_CYCLES == 0 || boot_q == BOOT_LAST)
                    st_nxt = RUN;
                else
                    boot_nxt = boot_q + 1'b1;
            end
            RUN: begin
                if (memstall) begin
                    {if_frz, ifr_frz, p_frz} = 3'b111;
                    st_nxt  = MEM_WAIT;
                    tmo_nxt = TW'(1);
                end else begin
                    go = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    {if_frz, ifr_frz, p_frz} = 3'b111;
                    if (tmo_q == TMO_MAX)
                        st_nxt = FAULT;
                    else
                        tmo_nxt = tmo_q + 1'b1;
                end else begin
                    st_nxt = RUN;
                    go     = 1'b1;
                end
            end
            FAULT: begin
                {if_frz, ifr_frz, p_frz} = 3'b111;
            end
            default: st_nxt = BOOT;
        endcase
        // Branch wins over the interlock: the stalled instruction is flushed anyway.
        if (go) begin
            if (bus.branch_taken) begin
                ifr_fl = 1'b1;
                idr_fl = 1'b1;
            end else if (hazard) begin
                if_frz  = 1'b1;
                ifr_frz = 1'b1;
                idr_fl  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= BOOT;
            boot_q  <= '0;
            tmo_q   <= '0;
            stall_q <= '0;
        end else begin
            st_q   <= st_nxt;
            boot_q <= boot_nxt;
            tmo_q  <= tmo_nxt;
            if ((st_q == RUN || st_q == MEM_WAIT) &&
                (if_frz || p_frz) && !(&stall_q))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.if_freeze    = if_frz;
    assign bus.ifreg_freeze = ifr_frz;
    assign bus.ifreg_flush  = ifr_fl;
    assign bus.idreg_flush  = idr_fl;
    assign bus.pipe_freeze  = p_frz;
    assign bus.fault        = (st_q == FAULT);
    assign bus.state        = st_q;
    assign bus.stall_cnt    = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a
// short-timeout, 4-bit-counter instance sharing the same stimulus.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] src1, src2, ex_dest, mem_dest;
    logic two_src, ex_wb_en, mem_wb_en;
    logic branch_taken, mem_req, mem_ready;
    int nchk = 0;
    int nerr = 0;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] FRZ  = 5'b11001;
    localparam logic [4:0] HAZ  = 5'b11010;
    localparam logic [4:0] BR   = 5'b00110;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(16)) bus1 ();
    pipe_ctrl_if #(.CNT_W(4))  bus2 ();

    assign bus1.src1 = src1;       assign bus2.src1 = src1;
    assign bus1.src2 = src2;       assign bus2.src2 = src2;
    assign bus1.two_src = two_src; assign bus2.two_src = two_src;
    assign bus1.ex_dest = ex_dest; assign bus2.ex_dest = ex_dest;
    assign bus1.mem_dest = mem_dest;   assign bus2.mem_dest = mem_dest;
    assign bus1.ex_wb_en = ex_wb_en;   assign bus2.ex_wb_en = ex_wb_en;
    assign bus1.mem_wb_en = mem_wb_en; assign bus2.mem_wb_en = mem_wb_en;
    assign bus1.branch_taken = branch_taken;
    assign bus2.branch_taken = branch_taken;
    assign bus1.mem_req = mem_req;     assign bus2.mem_req = mem_req;
    assign bus1.mem_ready = mem_ready; assign bus2.mem_ready = mem_ready;

    pipe_ctrl dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipe_ctrl #(.MEM_TIMEOUT(5), .CNT_W(4))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [4:0] o1, o2;
    assign o1 = {bus1.if_freeze, bus1.ifreg_freeze, bus1.ifreg_flush,
                 bus1.idreg_flush, bus1.pipe_freeze};
    assign o2 = {bus2.if_freeze, bus2.ifreg_freeze, bus2.ifreg_flush,
                 bus2.idreg_flush, bus2.pipe_freeze};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        src1 = 4'd1; src2 = 4'd2; two_src = 1'b0;
        ex_dest = 4'd0; mem_dest = 4'd0;
        ex_wb_en = 1'b0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        chk("rst_state", 32'(bus1.state), 32'd0);
        chk("rst_outs", 32'(o1), 32'(FRZ));
        chk("rst_stall", 32'(bus1.stall_cnt), 32'd0);
        chk("rst_fault", 32'(bus1.fault), 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("boot_state%0d", i), 32'(bus1.state), 32'd0);
            chk($sformatf("boot_outs%0d", i), 32'(o1), 32'(FRZ));
            cyc();
        end
        #1;
        chk("run_state", 32'(bus1.state), 32'd1);
        chk("run_idle", 32'(o1), 32'(NONE));
        chk("run_stall0", 32'(bus1.stall_cnt), 32'd0);

        src1 = 4'd3; ex_dest = 4'd3; ex_wb_en = 1'b1;
        #1;
        chk("ex_haz", 32'(o1), 32'(HAZ));
        cyc();
        ex_wb_en = 1'b0;
        #1;
        chk("ex_haz_stall", 32'(bus1.stall_cnt), 32'd1);
        chk("ex_haz_clear", 32'(o1), 32'(NONE));

        src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1; two_src = 1'b1;
        #1;
        chk("mem_haz_src2", 32'(o1), 32'(HAZ));
        two_src = 1'b0;
        #1;
        chk("mem_haz_one_src", 32'(o1), 32'(NONE));
        cyc();
        mem_wb_en = 1'b0;
        #1;
        chk("one_src_stall", 32'(bus1.stall_cnt), 32'd1);

        ex_wb_en = 1'b1; branch_taken = 1'b1;
        #1;
        chk("br_over_haz", 32'(o1), 32'(BR));
        cyc();
        idle();
        #1;
        chk("br_stall", 32'(bus1.stall_cnt), 32'd1);

        mem_req = 1'b1;
        #1;
        chk("mem_entry_outs", 32'(o1), 32'(FRZ));
        chk("mem_entry_state", 32'(bus1.state), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk($sformatf("mw_state%0d", i), 32'(bus1.state), 32'd2);
            chk($sformatf("mw_outs%0d", i), 32'(o1), 32'(FRZ));
        end
        cyc();
        mem_ready = 1'b1; branch_taken = 1'b1;
        #1;
        chk("mw_rel_state", 32'(bus1.state), 32'd2);
        chk("mw_rel_branch", 32'(o1), 32'(BR));
        cyc();
        idle();
        #1;
        chk("mw_after_state", 32'(bus1.state), 32'd1);
        chk("mw_after_outs", 32'(o1), 32'(NONE));
        chk("mw_stall", 32'(bus1.stall_cnt), 32'd5);
        chk("mw_stall2", 32'(bus2.stall_cnt), 32'd5);

        mem_req = 1'b1;
        #1;
        chk("to_entry", 32'(bus2.state), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk($sformatf("to_wait%0d", i), 32'(bus2.state), 32'd2);
            chk($sformatf("to_fault_lo%0d", i), 32'(bus2.fault), 32'd0);
        end
        cyc();
        #1;
        chk("to_state", 32'(bus2.state), 32'd3);
        chk("to_fault", 32'(bus2.fault), 32'd1);
        chk("to_outs", 32'(o2), 32'(FRZ));
        mem_req = 1'b0; mem_ready = 1'b1;
        repeat (3) cyc();
        #1;
        chk("fault_sticky", 32'(bus2.state), 32'd3);
        chk("fault_stall", 32'(bus2.stall_cnt), 32'd11);

        rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus2.state), 32'd0);
        chk("arst_fault", 32'(bus2.fault), 32'd0);
        chk("arst_stall", 32'(bus2.stall_cnt), 32'd0);
        chk("arst_outs", 32'(o2), 32'(FRZ));
        cyc();
        idle();
        rst = 1'b0;
        repeat (4) cyc();
        #1;
        chk("reboot_state", 32'(bus2.state), 32'd1);

        src1 = 4'd3; ex_dest = 4'd3; ex_wb_en = 1'b1;
        repeat (20) cyc();
        #1;
        chk("sat_stall", 32'(bus2.stall_cnt), 32'd15);
        chk("nosat_stall", 32'(bus1.stall_cnt), 32'd20);
        chk("sat_outs", 32'(o2), 32'(HAZ));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
